// File: rtl/fp_rf_context_engine.sv
// FP register file bulk save/restore sequencer for context switch and trap entry/exit.
// Optional XOR checksum of transferred words: define FP_CTX_CHECKSUM_EN.
module fp_rf_context_engine #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 32,
    parameter int STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rf_read_idx,
    input  logic [31:0]       rf_read_data,
    output logic              rf_write_en,
    output logic [4:0]        rf_write_idx,
    output logic [31:0]       rf_write_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
`ifdef FP_CTX_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_REQ,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [4:0]        rd_idx_q, rd_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
`ifdef FP_CTX_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            op_q     <= 1'b0;
            base_q   <= '0;
            rd_idx_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef FP_CTX_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            base_q   <= base_d;
            rd_idx_q <= rd_idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef FP_CTX_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        base_d   = base_q;
        rd_idx_d = rd_idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef FP_CTX_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    base_d  = base_addr;
                    idx_d   = '0;
                    state_d = op ? S_REQ : S_RD;
`ifdef FP_CTX_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_RD: begin
                // The read index is remembered so it holds outside RD.
                rd_idx_d = idx_q;
                wdata_d  = rf_read_data;
                state_d  = S_REQ;
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (op_q) begin
                        rdata_d = mem_rdata;
                        state_d = S_WB;
`ifdef FP_CTX_CHECKSUM_EN
                        csum_d  = csum_q ^ mem_rdata;
`endif
                    end else begin
`ifdef FP_CTX_CHECKSUM_EN
                        csum_d = csum_q ^ wdata_q;
`endif
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_WB: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign rf_read_idx   = (state_q == S_RD) ? idx_q : rd_idx_q;
    assign rf_write_en   = (state_q == S_WB);
    assign rf_write_idx  = idx_q;
    assign rf_write_data = rdata_q;
    assign mem_req       = (state_q == S_REQ);
    assign mem_we        = (state_q == S_REQ) && !op_q;
    assign mem_addr      = base_q + ADDR_W'(idx_q) * ADDR_W'(STRIDE);
    assign mem_wdata     = wdata_q;
`ifdef FP_CTX_CHECKSUM_EN
    assign checksum      = csum_q;
`endif

endmodule

// File: tb/tb_fp_rf_context_engine.sv
// Directed bench for fp_rf_context_engine with RF and memory models.
// Checksum port is exercised when FP_CTX_CHECKSUM_EN is defined.
module tb_fp_rf_context_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic [4:0]  rf_read_idx;
    logic [31:0] rf_read_data;
    logic        rf_write_en;
    logic [4:0]  rf_write_idx;
    logic [31:0] rf_write_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef FP_CTX_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] rf [32];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] st_addr [64];
    logic [31:0] st_data [64];
    logic        resp_ack = 1'b0;
    logic        ack_inject = 1'b0;
    int          ack_delay = 0;
    int          wcnt = 0;
    int          st_cnt = 0;
    int          wr_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rf_read_data = rf[rf_read_idx];
    assign mem_ack      = resp_ack | ack_inject;

    fp_rf_context_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .rf_read_idx  (rf_read_idx),
        .rf_read_data (rf_read_data),
        .rf_write_en  (rf_write_en),
        .rf_write_idx (rf_write_idx),
        .rf_write_data(rf_write_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
`ifdef FP_CTX_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    // Memory responder: ack after ack_delay wait cycles of mem_req.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt >= ack_delay) begin
                resp_ack  = 1'b1;
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                wcnt      = 0;
            end else begin
                resp_ack = 1'b0;
                wcnt++;
            end
        end else begin
            resp_ack = 1'b0;
            wcnt     = 0;
        end
    end

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] = mem_wdata;
            if (st_cnt < 64) begin
                st_addr[st_cnt] = mem_addr;
                st_data[st_cnt] = mem_wdata;
            end
            st_cnt++;
        end
        if (rf_write_en) begin
            rf[rf_write_idx] = rf_write_data;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input logic o, input logic [31:0] b,
                            input int poke, output int lat);
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        base_addr = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op        = 1'b0;
        base_addr = 32'hDEAD_0000;
        lat       = 1;
        check("busy_on_start", busy, 32'd1);
        while (!done && lat < 2000) begin
            if (lat == poke) begin
                start     = 1'b1;
                op        = ~o;
                base_addr = 32'h0BAD_0000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", done, 32'd1);
        @(posedge clk);
        #1;
        check("done_pulse", done, 32'd0);
        check("idle_busy", busy, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic [31:0] xsum;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        base_addr = '0;
        mem_rdata = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 + i;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_mem_req", mem_req, 32'd0);
        check("rst_wr_en", rf_write_en, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rd_idx", rf_read_idx, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // SAVE, zero-wait ack
        st_cnt = 0;
        wr_cnt = 0;
        ack_delay = 0;
        run_xfer(1'b0, 32'h1000, -1, lat);
        check("save_latency", lat, 32'd65);
        check("save_stores", st_cnt, 32'd32);
        check("save_no_wr", wr_cnt, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("save_addr%0d", i), st_addr[i], 32'h1000 + 4 * i);
            check($sformatf("save_data%0d", i), st_data[i], 32'hA500_0000 + i);
        end
`ifdef FP_CTX_CHECKSUM_EN
        xsum = '0;
        for (int i = 0; i < 32; i++) xsum ^= 32'hA500_0000 + i;
        check("save_csum", checksum, xsum);
`endif

        // RESTORE, three wait cycles per access
        for (int i = 0; i < 32; i++) mem[32'h2000 + 4 * i] = i * 3;
        wr_cnt = 0;
        ack_delay = 3;
        run_xfer(1'b1, 32'h2000, -1, lat);
        check("rest_latency", lat, 32'd161);
        check("rest_writes", wr_cnt, 32'd32);
        for (int i = 0; i < 32; i++)
            check($sformatf("rest_rf%0d", i), rf[i], i * 3);
`ifdef FP_CTX_CHECKSUM_EN
        xsum = '0;
        for (int i = 0; i < 32; i++) xsum ^= i * 3;
        check("rest_csum", checksum, xsum);
`endif

        // Start pulsed mid-SAVE, then mem_ack in IDLE
        for (int i = 0; i < 32; i++) rf[i] = 32'h1234_0000 + i;
        st_cnt = 0;
        wr_cnt = 0;
        ack_delay = 1;
        run_xfer(1'b0, 32'h4000, 10, lat);
        check("poke_latency", lat, 32'd97);
        check("poke_stores", st_cnt, 32'd32);
        check("poke_no_wr", wr_cnt, 32'd0);
        check("poke_last_addr", st_addr[31], 32'h407C);
        check("poke_last_data", st_data[31], 32'h1234_001F);
        @(negedge clk);
        ack_inject = 1'b1;
        @(posedge clk);
        #1;
        ack_inject = 1'b0;
        check("idle_ack_busy", busy, 32'd0);
        check("idle_ack_req", mem_req, 32'd0);
        check("idle_ack_done", done, 32'd0);
        check("idle_ack_stores", st_cnt, 32'd32);

        // Reset during RESTORE at idx 10
        for (int i = 0; i < 32; i++) begin
            rf[i] = 32'hC0DE_0000 + i;
            mem[32'h3000 + 4 * i] = 32'h5A00_0000 + i;
        end
        ack_delay = 0;
        @(negedge clk);
        start     = 1'b1;
        op        = 1'b1;
        base_addr = 32'h3000;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(mem_req && mem_addr == 32'h3028) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach", mem_addr, 32'h3028);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 32'd0);
        check("abort_done", done, 32'd0);
        check("abort_req", mem_req, 32'd0);
        check("abort_we", mem_we, 32'd0);
        check("abort_wr_en", rf_write_en, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        check("abort_rd_idx", rf_read_idx, 32'd0);
        check("abort_wr_idx", rf_write_idx, 32'd0);
        check("abort_wr_data", rf_write_data, 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_stay_idle", busy, 32'd0);
        for (int i = 0; i < 32; i++)
            check($sformatf("abort_rf%0d", i), rf[i],
                  (i < 10) ? 32'h5A00_0000 + i : 32'hC0DE_0000 + i);

        // SAVE with wrapping address
        for (int i = 0; i < 32; i++) rf[i] = 32'h9E37_79B9 * (i + 1);
        st_cnt = 0;
        ack_delay = 0;
        run_xfer(1'b0, 32'hFFFF_FFF8, -1, lat);
        check("wrap_latency", lat, 32'd65);
        check("wrap_a0", st_addr[0], 32'hFFFF_FFF8);
        check("wrap_a1", st_addr[1], 32'hFFFF_FFFC);
        check("wrap_a2", st_addr[2], 32'h0000_0000);
        check("wrap_a3", st_addr[3], 32'h0000_0004);
        check("wrap_a31", st_addr[31], 32'h0000_0074);
        check("wrap_d31", st_data[31], 32'h9E37_79B9 * 32);
`ifdef FP_CTX_CHECKSUM_EN
        xsum = '0;
        for (int i = 0; i < 32; i++) xsum ^= 32'h9E37_79B9 * (i + 1);
        check("wrap_csum", checksum, xsum);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
